// File: rtl/cmd_response_checker.sv
// cmd_response_checker: serially recomputes CRC7 over a 48-bit card response and
// reports frame/index/CRC error flags plus card status with a one-cycle done strobe.
module cmd_response_checker #(
  parameter bit         CRC_EN       = 1'b1,
  parameter logic [5:0] NO_CRC_INDEX = 6'h3F
) (
  input  logic        CLK_host,
  input  logic        reset,
  input  logic        resp_valid,
  input  logic [47:0] cmd_response,
  input  logic [5:0]  expected_index,
  output logic        checker_busy,
  output logic        check_done,
  output logic        crc_error,
  output logic        index_error,
  output logic        frame_error,
  output logic        resp_overrun,
  output logic [31:0] response_status,
  output logic [5:0]  response_index
);
  typedef enum logic [1:0] {IDLE, CALC, REPORT} state_t;
  state_t r_state, w_next;
  logic [47:0] r_resp;
  logic [5:0]  r_exp;
  logic [6:0]  r_crc;
  logic [5:0]  r_cnt;
  logic        w_capture, w_bit, w_fb, w_skip;
  logic [5:0]  w_pos;
  logic [6:0]  w_crc_nxt;
  assign w_capture = (r_state == IDLE) && resp_valid && !checker_busy;
  assign w_pos     = 6'd47 - r_cnt;
  assign w_bit     = r_resp[w_pos];
  assign w_fb      = r_crc[6] ^ w_bit;
  assign w_crc_nxt = {r_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
  // R3-style responses carry no meaningful CRC or echoed index
  assign w_skip    = r_resp[45:40] == NO_CRC_INDEX;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_capture ? CALC : IDLE) :
             (r_state == CALC) ? (r_cnt == 6'd39 ? REPORT : CALC) : IDLE;
  end
  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) begin
      r_resp          <= '0;
      r_exp           <= '0;
      r_crc           <= '0;
      r_cnt           <= '0;
      checker_busy    <= 1'b0;
      check_done      <= 1'b0;
      crc_error       <= 1'b0;
      index_error     <= 1'b0;
      frame_error     <= 1'b0;
      resp_overrun    <= 1'b0;
      response_status <= '0;
      response_index  <= '0;
    end else begin
      if (resp_valid && checker_busy) resp_overrun <= 1'b1;
      if (w_capture) begin
        r_resp          <= cmd_response;
        r_exp           <= expected_index;
        r_crc           <= '0;
        r_cnt           <= '0;
        crc_error       <= 1'b0;
        index_error     <= 1'b0;
        frame_error     <= 1'b0;
        response_status <= cmd_response[39:8];
        response_index  <= cmd_response[45:40];
        checker_busy    <= 1'b1;
      end
      if (r_state == CALC) begin
        r_crc <= w_crc_nxt;
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == REPORT) begin
        crc_error   <= CRC_EN && !w_skip && (r_crc != r_resp[7:1]);
        index_error <= !w_skip && (r_resp[45:40] != r_exp);
        frame_error <= r_resp[47] || r_resp[46] || !r_resp[0];
        check_done  <= 1'b1;
      end
      if (check_done) begin
        check_done   <= 1'b0;
        checker_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cmd_response_checker.sv
// tb_cmd_response_checker: directed and random responses checked against a
// polynomial-division CRC7 model and field rules.
module tb_cmd_response_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        resp_valid = 1'b0;
  logic [47:0] cmd_response = '0;
  logic [5:0]  expected_index = '0;
  logic        checker_busy, check_done, crc_error, index_error, frame_error, resp_overrun;
  logic [31:0] response_status;
  logic [5:0]  response_index;
  int          checks = 0;
  int          errors = 0;
  logic        exp_ovr = 1'b0;

  cmd_response_checker dut (
    .CLK_host(clk), .reset(reset), .resp_valid(resp_valid), .cmd_response(cmd_response),
    .expected_index(expected_index), .checker_busy(checker_busy), .check_done(check_done),
    .crc_error(crc_error), .index_error(index_error), .frame_error(frame_error),
    .resp_overrun(resp_overrun), .response_status(response_status),
    .response_index(response_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] d;
    d = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (d[i]) d = d ^ (47'h89 << (i - 7));
    return d[6:0];
  endfunction

  function automatic logic [47:0] junk();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({checker_busy, check_done, crc_error, index_error, frame_error,
                             resp_overrun, response_status, response_index}), 64'd0);
  endtask

  task automatic run_resp(input logic [47:0] r, input logic [5:0] e, input int ovr_at);
    logic sk, ce, ie, fe;
    int lat, dones;
    sk = r[45:40] == 6'h3F;
    ce = !sk && (crc7_ref(r[47:8]) != r[7:1]);
    ie = !sk && (r[45:40] != e);
    fe = r[47] || r[46] || !r[0];
    lat = 0;
    dones = 0;
    @(negedge clk);
    cmd_response = r;
    expected_index = e;
    resp_valid = 1'b1;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    cmd_response = junk();
    expected_index = 6'(~e);
    chk("busy_cap", 64'(checker_busy), 64'd1);
    chk("flags_clr", 64'({crc_error, index_error, frame_error}), 64'd0);
    chk("status_cap", 64'(response_status), 64'(r[39:8]));
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      if (check_done) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          chk("crc_error", 64'(crc_error), 64'(ce));
          chk("index_error", 64'(index_error), 64'(ie));
          chk("frame_error", 64'(frame_error), 64'(fe));
          chk("status", 64'(response_status), 64'(r[39:8]));
          chk("index", 64'(response_index), 64'(r[45:40]));
          chk("busy_done", 64'(checker_busy), 64'd1);
        end
      end
      if (n == 42) chk("idle_after", 64'({checker_busy, check_done}), 64'd0);
      if (n == ovr_at) begin
        resp_valid = 1'b1;
        cmd_response = junk();
        exp_ovr = 1'b1;
      end
    end
    chk("latency", 64'(lat), 64'd41);
    chk("one_done", 64'(dones), 64'd1);
    chk("hold", 64'({crc_error, index_error, frame_error, response_status, response_index}),
        64'({ce, ie, fe, r[39:8], r[45:40]}));
    chk("overrun", 64'(resp_overrun), 64'(exp_ovr));
  endtask

  initial begin
    logic [47:0] r;
    logic [5:0]  e;
    int ovr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      resp_valid = i[0];
      cmd_response = 48'h11_0000_0900_67;
      #1 check_all_zero("reset_hold");
    end
    @(negedge clk);
    resp_valid = 1'b0;
    reset = 1'b1;
    run_resp(48'h11_0000_0900_67, 6'h11, 0);
    run_resp(48'h11_0000_0900_65, 6'h11, 0);
    run_resp(48'h11_0000_0900_67, 6'h12, 0);
    run_resp(48'h40_0000_0000_95, 6'h00, 0);
    run_resp(48'h3F_80FF_8000_FF, 6'h29, 0);
    run_resp(48'h11_0000_0900_67, 6'h11, 10);
    run_resp(48'h11_0000_0900_65, 6'h11, 41);
    @(negedge clk);
    cmd_response = 48'h11_0000_0900_65;
    expected_index = 6'h12;
    resp_valid = 1'b1;
    @(posedge clk);
    #1 resp_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    exp_ovr = 1'b0;
    #1 check_all_zero("abort");
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b1;
      resp_valid = 1'b0;
      #1;
      if (check_done) chk("abort_no_done", 64'(check_done), 64'd0);
    end
    chk("abort_quiet", 64'({checker_busy, check_done, crc_error, index_error, frame_error}), 64'd0);
    run_resp(48'h11_0000_0900_67, 6'h11, 0);
    for (int k = 0; k < 30; k++) begin
      r = junk();
      if ($urandom_range(3) != 0) begin
        r[47] = 1'b0;
        r[46] = 1'b0;
        r[0] = 1'b1;
      end
      if ($urandom_range(4) == 0) r[45:40] = 6'h3F;
      if ($urandom_range(1) == 0) r[7:1] = crc7_ref(r[47:8]);
      e = ($urandom_range(1) == 0) ? r[45:40] : 6'($urandom);
      ovr = ($urandom_range(5) == 0) ? int'($urandom_range(41, 1)) : 0;
      run_resp(r, e, ovr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
